// File: rtl/control_unit_if.sv
// control_unit_if: data_path/memory control bundle driven by control_unit, with IR and flags fed back.
interface control_unit_if;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load;
  logic       MAR_Load;
  logic       PC_Load;
  logic       PC_Inc;
  logic       A_Load;
  logic       B_Load;
  logic [2:0] ALU_Sel;
  logic       CCR_Load;
  logic [1:0] Bus1_Sel;
  logic [1:0] Bus2_Sel;
  logic       write;
  modport master (
    input  IR, CCR_Result,
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
  );
  modport slave (
    output IR, CCR_Result,
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer producing every data_path control and the memory write strobe.
module control_unit #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001,
  parameter logic [2:0] ALU_AND = 3'b010,
  parameter logic [2:0] ALU_OR  = 3'b011
) (
  input logic             Clk,
  input logic             Reset,
  control_unit_if.master  bus
);
  typedef enum logic [4:0] {
    FETCH_0, FETCH_1, FETCH_2, DECODE_3,
    LDI_4, LDI_5, LDI_6,
    LDD_4, LDD_5, LDD_6, LDD_7, LDD_8,
    ST_4, ST_5, ST_6, ST_7,
    ALU_4,
    BR_4, BR_5, BR_6, BRN_4
  } state_t;
  typedef struct packed {
    logic       ir_load;
    logic       mar_load;
    logic       pc_load;
    logic       pc_inc;
    logic       a_load;
    logic       b_load;
    logic [2:0] alu_sel;
    logic       ccr_load;
    logic [1:0] bus1_sel;
    logic [1:0] bus2_sel;
    logic       write;
  } ctl_t;
  state_t     state, nxt;
  logic       use_b, nxt_b, taken;
  logic [2:0] alu;
  ctl_t       ctl, o;
  function automatic ctl_t dec(input state_t s, input logic b, input logic [2:0] a);
    ctl_t c;
    c = '0;
    case (s)
      FETCH_0, LDI_4, LDD_4, ST_4, BR_4: begin c.mar_load = 1'b1; c.bus2_sel = 2'b01; end
      FETCH_1, LDI_5, LDD_5, ST_5, BRN_4: c.pc_inc = 1'b1;
      FETCH_2: begin c.ir_load = 1'b1; c.bus2_sel = 2'b10; end
      LDD_6, ST_6: begin c.mar_load = 1'b1; c.bus2_sel = 2'b10; end
      LDI_6, LDD_8: begin c.a_load = !b; c.b_load = b; c.bus2_sel = 2'b10; end
      ST_7: begin c.write = 1'b1; c.bus1_sel = b ? 2'b10 : 2'b01; end
      ALU_4: begin c.alu_sel = a; c.bus1_sel = 2'b01; c.a_load = 1'b1; c.ccr_load = 1'b1; end
      BR_6: begin c.pc_load = 1'b1; c.bus2_sel = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction
  assign taken = bus.IR == 8'h20 ||
                 (bus.IR == 8'h21 &&  bus.CCR_Result[3]) ||
                 (bus.IR == 8'h23 &&  bus.CCR_Result[2]) ||
                 (bus.IR == 8'h24 && !bus.CCR_Result[2]) ||
                 (bus.IR == 8'h27 &&  bus.CCR_Result[0]);
  always_comb begin
    nxt   = FETCH_0;
    nxt_b = use_b;
    alu   = ALU_ADD;
    case (state)
      FETCH_0: nxt = FETCH_1;
      FETCH_1: nxt = FETCH_2;
      FETCH_2: nxt = DECODE_3;
      DECODE_3:
        case (bus.IR)
          8'h86, 8'h88: begin nxt = LDI_4; nxt_b = bus.IR[3]; end
          8'h87, 8'h89: begin nxt = LDD_4; nxt_b = bus.IR[3]; end
          8'h96, 8'h97: begin nxt = ST_4; nxt_b = bus.IR[0]; end
          8'h42: begin nxt = ALU_4; alu = ALU_ADD; end
          8'h43: begin nxt = ALU_4; alu = ALU_SUB; end
          8'h44: begin nxt = ALU_4; alu = ALU_AND; end
          8'h45: begin nxt = ALU_4; alu = ALU_OR; end
          8'h20, 8'h21, 8'h23, 8'h24, 8'h27: nxt = taken ? BR_4 : BRN_4;
          default: nxt = FETCH_0;
        endcase
      LDI_4: nxt = LDI_5;
      LDI_5: nxt = LDI_6;
      LDD_4: nxt = LDD_5;
      LDD_5: nxt = LDD_6;
      LDD_6: nxt = LDD_7;
      LDD_7: nxt = LDD_8;
      ST_4: nxt = ST_5;
      ST_5: nxt = ST_6;
      ST_6: nxt = ST_7;
      BR_4: nxt = BR_5;
      BR_5: nxt = BR_6;
      default: nxt = FETCH_0;
    endcase
  end
  // ctl always holds the decode of the current state; Reset masks it so outputs drop the instant reset asserts
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state <= FETCH_0;
      use_b <= 1'b0;
      ctl   <= dec(FETCH_0, 1'b0, ALU_ADD);
    end else begin
      state <= nxt;
      use_b <= nxt_b;
      ctl   <= dec(nxt, nxt_b, alu);
    end
  assign o = Reset ? ctl : '0;
  assign bus.IR_Load  = o.ir_load;
  assign bus.MAR_Load = o.mar_load;
  assign bus.PC_Load  = o.pc_load;
  assign bus.PC_Inc   = o.pc_inc;
  assign bus.A_Load   = o.a_load;
  assign bus.B_Load   = o.b_load;
  assign bus.ALU_Sel  = o.alu_sel;
  assign bus.CCR_Load = o.ccr_load;
  assign bus.Bus1_Sel = o.bus1_sel;
  assign bus.Bus2_Sel = o.bus2_sel;
  assign bus.write    = o.write;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: vector table, hand-written reset/abort sequences and random opcodes against a cycle-list model.
module tb_control_unit;
  typedef struct packed {
    logic       il, ml, pl, pi, al, bl;
    logic [2:0] alu;
    logic       cl;
    logic [1:0] b1, b2;
    logic       wr;
  } obs_t;
  typedef struct {
    logic [7:0] ir;
    logic [3:0] ccr;
    int         probe;
    obs_t       want;
  } vec_t;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  control_unit_if bus();
  control_unit dut (.Clk(Clk), .Reset(Reset), .bus(bus.master));
  always #5 Clk = ~Clk;
  function automatic obs_t ob(input int il, ml, pl, pi, al, bl, alu, cl, b1, b2, wr);
    return {1'(il), 1'(ml), 1'(pl), 1'(pi), 1'(al), 1'(bl), 3'(alu), 1'(cl), 2'(b1), 2'(b2), 1'(wr)};
  endfunction
  function automatic obs_t cur();
    return {bus.IR_Load, bus.MAR_Load, bus.PC_Load, bus.PC_Inc, bus.A_Load, bus.B_Load,
            bus.ALU_Sel, bus.CCR_Load, bus.Bus1_Sel, bus.Bus2_Sel, bus.write};
  endfunction
  task automatic chk(input string nm, input obs_t want);
    obs_t a;
    logic [4:0] loads;
    a = cur();
    loads = {a.il, a.ml, a.pl, a.al, a.bl};
    n_chk++;
    if (a !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, want, $time);
    end
    n_chk++;
    if ((a.pl && a.pi) || (a.wr && |loads) || !$onehot0(loads)) begin
      n_fail++;
      $display("FAIL %s_invariant: got %h expected no load/inc/write conflict", nm, a);
    end
  endtask
  // Expected output sequence of one whole instruction, one entry per clock, fetch included
  task automatic model(input logic [7:0] ir, input logic [3:0] ccr);
    obs_t mar_pc, inc, mem_mar;
    bit tk;
    mar_pc  = ob(0,1,0,0,0,0,0,0,0,1,0);
    inc     = ob(0,0,0,1,0,0,0,0,0,0,0);
    mem_mar = ob(0,1,0,0,0,0,0,0,0,2,0);
    exp_q.delete();
    exp_q.push_back(mar_pc);
    exp_q.push_back(inc);
    exp_q.push_back(ob(1,0,0,0,0,0,0,0,0,2,0));
    exp_q.push_back('0);
    case (ir)
      8'h86, 8'h88: begin
        exp_q.push_back(mar_pc);
        exp_q.push_back(inc);
        exp_q.push_back(ob(0,0,0,0, ir == 8'h86, ir == 8'h88, 0,0,0,2,0));
      end
      8'h87, 8'h89: begin
        exp_q.push_back(mar_pc);
        exp_q.push_back(inc);
        exp_q.push_back(mem_mar);
        exp_q.push_back('0);
        exp_q.push_back(ob(0,0,0,0, ir == 8'h87, ir == 8'h89, 0,0,0,2,0));
      end
      8'h96, 8'h97: begin
        exp_q.push_back(mar_pc);
        exp_q.push_back(inc);
        exp_q.push_back(mem_mar);
        exp_q.push_back(ob(0,0,0,0,0,0,0,0, ir == 8'h96 ? 1 : 2, 0, 1));
      end
      8'h42, 8'h43, 8'h44, 8'h45: exp_q.push_back(ob(0,0,0,0,1,0, ir - 8'h42, 1, 1, 0, 0));
      8'h20, 8'h21, 8'h23, 8'h24, 8'h27: begin
        tk = ir == 8'h20 || (ir == 8'h21 && ccr[3]) || (ir == 8'h23 && ccr[2]) ||
             (ir == 8'h24 && !ccr[2]) || (ir == 8'h27 && ccr[0]);
        if (tk) begin
          exp_q.push_back(mar_pc);
          exp_q.push_back('0);
          exp_q.push_back(ob(0,0,1,0,0,0,0,0,0,2,0));
        end else exp_q.push_back(inc);
      end
      default: ;
    endcase
  endtask
  // IR/CCR change only after FETCH_0 so the previous instruction's DECODE never sees them
  task automatic run(input logic [7:0] ir, input logic [3:0] ccr, input int probe, input obs_t want);
    model(ir, ccr);
    foreach (exp_q[i]) begin
      @(negedge Clk);
      chk($sformatf("op%02h_cyc%0d", ir, i + 1), exp_q[i]);
      if (i == probe) chk($sformatf("vec%02h_cyc%0d", ir, i + 1), want);
      if (i == 0) begin
        bus.IR = ir;
        bus.CCR_Result = ccr;
      end
    end
  endtask
  initial begin
    vec_t vt[12];
    logic [7:0] ops[15];
    logic [7:0] r;
    ops = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43,
            8'h44, 8'h45, 8'h20, 8'h21, 8'h23, 8'h24, 8'h27};
    vt[0]  = '{8'h00, 4'b0000, 3, ob(0,0,0,0,0,0,0,0,0,0,0)};
    vt[1]  = '{8'h86, 4'b0000, 6, ob(0,0,0,0,1,0,0,0,0,2,0)};
    vt[2]  = '{8'h96, 4'b0000, 7, ob(0,0,0,0,0,0,0,0,1,0,1)};
    vt[3]  = '{8'h43, 4'b0000, 4, ob(0,0,0,0,1,0,1,1,1,0,0)};
    vt[4]  = '{8'h23, 4'b0100, 6, ob(0,0,1,0,0,0,0,0,0,2,0)};
    vt[5]  = '{8'h23, 4'b0000, 4, ob(0,0,0,1,0,0,0,0,0,0,0)};
    vt[6]  = '{8'h89, 4'b0000, 8, ob(0,0,0,0,0,1,0,0,0,2,0)};
    vt[7]  = '{8'h97, 4'b0000, 7, ob(0,0,0,0,0,0,0,0,2,0,1)};
    vt[8]  = '{8'h27, 4'b0001, 6, ob(0,0,1,0,0,0,0,0,0,2,0)};
    vt[9]  = '{8'h24, 4'b0100, 4, ob(0,0,0,1,0,0,0,0,0,0,0)};
    vt[10] = '{8'h45, 4'b1111, 4, ob(0,0,0,0,1,0,3,1,1,0,0)};
    vt[11] = '{8'h87, 4'b0000, 6, ob(0,1,0,0,0,0,0,0,0,2,0)};
    bus.IR = 8'h00;
    bus.CCR_Result = 4'h0;
    repeat (3) begin
      @(negedge Clk);
      chk("reset_low", '0);
    end
    @(posedge Clk);
    #1 Reset = 1'b1;
    foreach (vt[k]) run(vt[k].ir, vt[k].ccr, vt[k].probe, vt[k].want);
    model(8'h97, 4'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      chk($sformatf("stb_abort_cyc%0d", i + 1), exp_q[i]);
      if (i == 0) bus.IR = 8'h97;
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
    #1 chk("abort_in_s7", '0);
    repeat (2) begin
      @(negedge Clk);
      chk("abort_hold", '0);
    end
    @(posedge Clk);
    #1 Reset = 1'b1;
    run(8'h00, 4'h0, 0, ob(0,1,0,0,0,0,0,0,0,1,0));
    repeat (60) begin
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 14)];
      run(r, 4'($urandom), -1, '0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
